// File: rtl/btb_pkg.sv
// Shared types and width helpers for the branch target buffer.
// The optional BTB_STATS_EN macro enables the statistics counters in btb_predictor.
package btb_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned ENTRIES_DEF = 64;
   localparam int unsigned CNT_W_DEF   = 2;

   function automatic int unsigned idx_w(input int unsigned entries);
      return $clog2(entries);
   endfunction

   function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
      return xlen - 2 - idx_w(entries);
   endfunction

   // Counter value for a freshly allocated (weakly taken) entry
   function automatic int unsigned CNT_WEAK_T(input int unsigned cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   function automatic int unsigned CNT_WEAK_NT(input int unsigned cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

   localparam int unsigned TAG_W_DEF = XLEN_DEF - 2 - $clog2(ENTRIES_DEF);

   // Entry layout for the default configuration
   typedef struct packed {
      logic                  valid;
      logic [TAG_W_DEF-1:0]  tag;
      logic [XLEN_DEF-1:0]   target;
      logic [CNT_W_DEF-1:0]  cnt;
   } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating up/down counter next-state function used for the trained BTB entry.
module btb_sat_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             en,
   input  logic             up,
   output logic [CNT_W-1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (en) begin
         if (up && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + CNT_W'(1);
         end else if (!up && (cnt != {CNT_W{1'b0}})) begin
            cnt_next = cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction.
// Define BTB_STATS_EN to enable the branch/mispredict statistics counters.
module btb_predictor
   import btb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CNT_W   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_if,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] fix_pc,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int unsigned    IDX_W  = idx_w(ENTRIES);
   localparam int unsigned    TAG_W  = tag_w(XLEN, ENTRIES);
   localparam logic [CNT_W-1:0] CNT_T  = CNT_W'(CNT_WEAK_T(CNT_W));
   localparam logic [CNT_W-1:0] CNT_NT = CNT_W'(CNT_WEAK_NT(CNT_W));

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [CNT_W-1:0] cnt_q    [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, up_hit;
   logic [CNT_W-1:0] cnt_next;
   logic             unused_pc_lsbs;

   assign lk_idx = pc_if[IDX_W+1:2];
   assign lk_tag = pc_if[XLEN-1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[XLEN-1:IDX_W+2];
   assign unused_pc_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

   // Lookup reads the registered table only; a same-cycle update is not bypassed
   assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken  = rst && lk_hit && cnt_q[lk_idx][CNT_W-1];
   assign pred_target = pred_taken ? target_q[lk_idx] : pc_if + XLEN'(4);

   assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign mispredict = rst && upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
   assign fix_pc     = upd_taken ? upd_target : upd_pc + XLEN'(4);

   btb_sat_counter #(
      .CNT_W (CNT_W)
   ) u_sat_counter (
      .cnt      (cnt_q[up_idx]),
      .en       (upd_valid && up_hit),
      .up       (upd_taken),
      .cnt_next (cnt_next)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_NT;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            cnt_q[up_idx] <= cnt_next;
         end else if (upd_taken) begin
            valid_q[up_idx] <= 1'b1;
            cnt_q[up_idx]   <= CNT_T;
         end
      end
   end

   // Tag and target need no reset: they are ignored while valid is clear
   always_ff @(posedge clk) begin
      if (rst && upd_valid && upd_taken) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= upd_target;
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         if (upd_valid && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_q <= stat_br_q + 32'd1;
         end
         if (mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
            stat_mp_q <= stat_mp_q + 32'd1;
         end
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vectors plus a per-cycle behavioural model.
module tb_btb_predictor;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;
   localparam int CNT_W   = 2;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst;
   logic [31:0] pc_if;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] fix_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int checks   = 0;
   int failures = 0;

   btb_predictor #(
      .XLEN    (XLEN),
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_if            (pc_if),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .mispredict       (mispredict),
      .fix_pc           (fix_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: table state as plain arrays, outcome history as an integer counter
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_cnt    [ENTRIES];
   longint      m_br = 0;
   longint      m_mp = 0;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int unsigned m_tagof(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   initial begin
      int          i;
      logic        e_taken;
      logic [31:0] e_tgt;
      logic        e_mp;
      logic [31:0] e_br, e_mpc;
      forever begin
         @(negedge clk);
         i       = m_idx(pc_if);
         e_taken = rst && m_valid[i] && (m_tag[i] == m_tagof(pc_if)) &&
                   (m_cnt[i] >= (1 << (CNT_W - 1)));
         e_tgt   = e_taken ? m_target[i] : pc_if + 32'd4;
         e_mp    = rst && upd_valid && ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
`ifdef BTB_STATS_EN
         e_br  = (m_br > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_br[31:0];
         e_mpc = (m_mp > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_mp[31:0];
`else
         e_br  = 32'd0;
         e_mpc = 32'd0;
`endif
         chk("model_pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
         chk("model_pred_target", pred_target, e_tgt);
         chk("model_mispredict", {31'd0, mispredict}, {31'd0, e_mp});
         if (rst && upd_valid) begin
            chk("model_fix_pc", fix_pc, upd_taken ? upd_target : upd_pc + 32'd4);
         end
         chk("model_stat_branches", stat_branches, e_br);
         chk("model_stat_mispredicts", stat_mispredicts, e_mpc);

         // Advance the model to the state after the coming rising edge
         if (!rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
               m_valid[k] = 1'b0;
               m_cnt[k]   = (1 << (CNT_W - 1)) - 1;
            end
            m_br = 0;
            m_mp = 0;
         end else if (upd_valid) begin
            i = m_idx(upd_pc);
            m_br++;
            if (e_mp) m_mp++;
            if (m_valid[i] && (m_tag[i] == m_tagof(upd_pc))) begin
               if (upd_taken) begin
                  m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                  m_target[i] = upd_target;
               end else begin
                  m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
               end
            end else if (upd_taken) begin
               m_valid[i]  = 1'b1;
               m_tag[i]    = m_tagof(upd_pc);
               m_target[i] = upd_target;
               m_cnt[i]    = 1 << (CNT_W - 1);
            end
         end
      end
   end

   task automatic step(input logic r, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
      @(posedge clk);
      #1;
      rst             = r;
      pc_if           = pc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_taken       = ut;
      upd_target      = utgt;
      upd_pred_taken  = upt;
      upd_pred_target = uptgt;
      #2;
   endtask

   task automatic look(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
      step(1'b1, pc, 1'b1, upc, ut, utgt, upt, uptgt);
   endtask

   initial begin
      rst             = 1'b0;
      pc_if           = 32'h100;
      upd_valid       = 1'b0;
      upd_pc          = 32'd0;
      upd_taken       = 1'b0;
      upd_target      = 32'd0;
      upd_pred_taken  = 1'b0;
      upd_pred_target = 32'd0;

      // Reset with a coincident taken update that must be discarded
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_pred_target", pred_target, 32'h104);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      look(32'h100);
      chk("post_rst_miss", pred_target, 32'h104);

      // First taken update allocates; lookup in the same cycle sees old contents
      upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
      chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
      chk("alloc_fix_pc", fix_pc, 32'h40);
      chk("same_cycle_no_bypass", pred_target, 32'h104);
      look(32'h100);
      chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_pred_target", pred_target, 32'h40);

      // Weakly taken -> weakly not taken -> strongly not taken -> floor
      upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
      chk("nt1_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt1_fix_pc", fix_pc, 32'h104);
      look(32'h100);
      chk("cnt01_predicts_nt", pred_target, 32'h104);
      upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
      chk("nt2_no_mispredict", {31'd0, mispredict}, 32'd0);
      upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
      upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
      look(32'h100);
      chk("floor_saturation", pred_target, 32'h104);

      // Climb to the ceiling, then one not-taken keeps it taken
      upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
      upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
      upd(32'h100, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
      upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
      look(32'h100);
      chk("ceiling_saturation", pred_target, 32'h40);

      // 0x200 aliases 0x100 at index 0
      look(32'h200);
      chk("alias_miss", pred_target, 32'h204);
      upd(32'h200, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
      look(32'h200);
      chk("alias_replaced", pred_target, 32'h80);
      look(32'h100);
      chk("alias_evicted", pred_target, 32'h104);

      // Taken with a wrong target, then correct
      upd(32'h200, 32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
      chk("bad_target_mispredict", {31'd0, mispredict}, 32'd1);
      chk("bad_target_fix_pc", fix_pc, 32'h90);
      look(32'h200);
      chk("target_overwritten", pred_target, 32'h90);
      upd(32'h200, 32'h200, 1'b1, 32'h90, 1'b1, 32'h90);
      chk("correct_no_mispredict", {31'd0, mispredict}, 32'd0);

      upd(32'h1004, 32'h1004, 1'b1, 32'h2000, 1'b0, 32'h1008);
      look(32'h1004);
      chk("idx1_target", pred_target, 32'h2000);
      look(32'hFFFF_FFFC);
      chk("pc_plus4_wraps", pred_target, 32'h0);

      // Miss and not taken: no allocation
      upd(32'h300, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
      chk("miss_nt_fix_pc", fix_pc, 32'h304);
      look(32'h300);
      chk("miss_nt_no_alloc", pred_target, 32'h304);
`ifdef BTB_STATS_EN
      chk("stat_branches_14", stat_branches, 32'd14);
      chk("stat_mispredicts_8", stat_mispredicts, 32'd8);
`endif

      // Mid-stream reset pulse with a coincident update
      step(1'b0, 32'h200, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
      chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("midrst_pred_target", pred_target, 32'h204);
      look(32'h200);
      chk("cleared_0x200", pred_target, 32'h204);
      look(32'h300);
      chk("discarded_0x300", pred_target, 32'h304);
      look(32'h1004);
      chk("cleared_0x1004", pred_target, 32'h1008);
      chk("stat_branches_cleared", stat_branches, 32'd0);
      chk("stat_mispredicts_cleared", stat_mispredicts, 32'd0);

      look(32'h0);
      look(32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
